// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forwarding selects,
// FSM states and the per-stage shadow scoreboard entry.
package hazard_ctrl_pkg;

  // Scoreboard rd field is sized for the widest supported register index.
  // Narrower indices are zero-extended before they are stored or compared.
  localparam int unsigned RD_MAX_W = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    MEM_WAIT
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
    logic                is_mem;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // True when the entry will write a non-x0 register that matches r.
  function automatic logic sb_writes(input sb_entry_t e, input logic [RD_MAX_W-1:0] r);
    return e.valid & e.regwrite & (e.rd != '0) & (e.rd == r);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. With HAZARD_PERF_EN defined
// the bundle also carries the three performance counters.
interface hazard_ctrl_if #(
  parameter int unsigned RWIDTH = 5
);
  logic              id_valid_i;
  logic [RWIDTH-1:0] id_rs1_i;
  logic [RWIDTH-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [RWIDTH-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_is_load_i;
  logic              id_is_mem_i;
  logic [RWIDTH-1:0] ex_rs1_i;
  logic [RWIDTH-1:0] ex_rs2_i;
  logic              brtaken_i;
  logic              dmem_ready_i;
  logic              stall_f_o;
  logic              stall_d_o;
  logic              stall_m_o;
  logic              flush_f_o;
  logic              flush_d_o;
  logic              pc_sel_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              err_o;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_ld_stall_o;
  logic [31:0]       perf_flush_o;
  logic [31:0]       perf_mem_wait_o;
`endif

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_regwrite_i, id_is_load_i, id_is_mem_i,
           ex_rs1_i, ex_rs2_i, brtaken_i, dmem_ready_i,
    input  stall_f_o, stall_d_o, stall_m_o, flush_f_o, flush_d_o,
           pc_sel_o, fwd_a_o, fwd_b_o, err_o
`ifdef HAZARD_PERF_EN
         , perf_ld_stall_o, perf_flush_o, perf_mem_wait_o
`endif
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_regwrite_i, id_is_load_i, id_is_mem_i,
           ex_rs1_i, ex_rs2_i, brtaken_i, dmem_ready_i,
    output stall_f_o, stall_d_o, stall_m_o, flush_f_o, flush_d_o,
           pc_sel_o, fwd_a_o, fwd_b_o, err_o
`ifdef HAZARD_PERF_EN
         , perf_ld_stall_o, perf_flush_o, perf_mem_wait_o
`endif
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// ALU operand forwarding compare for one source register; MEM beats WB,
// loads in MEM are not forwardable and x0 is never forwarded.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  sb_entry_t           mem,
  input  sb_entry_t           wb,
  input  logic [RD_MAX_W-1:0] rs,
  output fwd_sel_e            sel
);

  always_comb begin
    sel = FWD_RF;
    if (sb_writes(mem, rs) && !mem.is_load) begin
      sel = FWD_MEM;
    end else if (sb_writes(wb, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: shadow scoreboard, forwarding, load-use
// stall, branch flush and data-memory freeze. Optional macro: HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned RWIDTH      = 5,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  sb_entry_t     ex_q, mem_q, wb_q, id_entry;
  hz_state_e     state;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic          err_q;
  logic          frozen, branch, ld_use;
  fwd_sel_e      fwd_a, fwd_b;

  logic [RWIDTH-1:0]   id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2;
  logic [RD_MAX_W-1:0] id_rs1_w, id_rs2_w, ex_rs1_w, ex_rs2_w;

  assign id_rs1   = hz.id_rs1_i;
  assign id_rs2   = hz.id_rs2_i;
  assign id_rd    = hz.id_rd_i;
  assign ex_rs1   = hz.ex_rs1_i;
  assign ex_rs2   = hz.ex_rs2_i;
  assign id_rs1_w = RD_MAX_W'(id_rs1);
  assign id_rs2_w = RD_MAX_W'(id_rs2);
  assign ex_rs1_w = RD_MAX_W'(ex_rs1);
  assign ex_rs2_w = RD_MAX_W'(ex_rs2);

  assign frozen = mem_q.valid & mem_q.is_mem & ~hz.dmem_ready_i;
  assign branch = ~frozen & ex_q.valid & hz.brtaken_i;
  assign ld_use = ~frozen & ~branch & ex_q.valid & ex_q.is_load & (ex_q.rd != '0)
                & hz.id_valid_i
                & ((hz.id_use_rs1_i & (id_rs1_w == ex_q.rd))
                 | (hz.id_use_rs2_i & (id_rs2_w == ex_q.rd)));

  always_comb begin
    id_entry          = SB_EMPTY;
    id_entry.valid    = hz.id_valid_i & ~(branch | ld_use);
    id_entry.rd       = RD_MAX_W'(id_rd);
    id_entry.regwrite = hz.id_regwrite_i;
    id_entry.is_load  = hz.id_is_load_i;
    id_entry.is_mem   = hz.id_is_mem_i;
  end

  // Counter restarts at 1 on entry to MEM_WAIT so it equals the number of
  // completed wait cycles, then saturates at MEM_TIMEOUT-1.
  always_comb begin
    cnt_nxt = wait_cnt;
    if (state != MEM_WAIT) begin
      cnt_nxt = CW'(1);
    end else if (wait_cnt != CNT_LAST) begin
      cnt_nxt = wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= SB_EMPTY;
      mem_q    <= SB_EMPTY;
      wb_q     <= SB_EMPTY;
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (frozen) begin
      state    <= MEM_WAIT;
      wait_cnt <= cnt_nxt;
      if (cnt_nxt == CNT_LAST) begin
        err_q <= 1'b1;
      end
    end else begin
      state    <= ld_use ? LD_STALL : RUN;
      wait_cnt <= '0;
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= id_entry;
    end
  end

  fwd_unit u_fwd_a (.mem(mem_q), .wb(wb_q), .rs(ex_rs1_w), .sel(fwd_a));
  fwd_unit u_fwd_b (.mem(mem_q), .wb(wb_q), .rs(ex_rs2_w), .sel(fwd_b));

  assign hz.stall_f_o = frozen | ld_use;
  assign hz.stall_d_o = frozen;
  assign hz.stall_m_o = frozen;
  assign hz.flush_f_o = branch;
  assign hz.flush_d_o = branch | ld_use;
  assign hz.pc_sel_o  = branch;
  assign hz.fwd_a_o   = fwd_a;
  assign hz.fwd_b_o   = fwd_b;
  assign hz.err_o     = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_ld_stall, perf_flush, perf_mem_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ld_stall <= '0;
      perf_flush    <= '0;
      perf_mem_wait <= '0;
    end else begin
      if (ld_use) perf_ld_stall <= perf_ld_stall + 32'd1;
      if (branch) perf_flush    <= perf_flush + 32'd1;
      if (frozen) perf_mem_wait <= perf_mem_wait + 32'd1;
    end
  end

  assign hz.perf_ld_stall_o = perf_ld_stall;
  assign hz.perf_flush_o    = perf_flush;
  assign hz.perf_mem_wait_o = perf_mem_wait;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, load-use, branch flush,
// memory freeze, timeout error and x0 handling.
module tb_hazard_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  hazard_ctrl_if #(.RWIDTH(5)) hz ();

  hazard_ctrl #(.RWIDTH(5), .MEM_TIMEOUT(64)) u_dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic sf, input logic sd, input logic sm,
                           input logic ff, input logic fd, input logic pc);
    check_eq({tag, ".stall_f"}, 32'(hz.stall_f_o), 32'(sf));
    check_eq({tag, ".stall_d"}, 32'(hz.stall_d_o), 32'(sd));
    check_eq({tag, ".stall_m"}, 32'(hz.stall_m_o), 32'(sm));
    check_eq({tag, ".flush_f"}, 32'(hz.flush_f_o), 32'(ff));
    check_eq({tag, ".flush_d"}, 32'(hz.flush_d_o), 32'(fd));
    check_eq({tag, ".pc_sel"},  32'(hz.pc_sel_o),  32'(pc));
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    check_eq({tag, ".fwd_a"}, 32'(hz.fwd_a_o), 32'(a));
    check_eq({tag, ".fwd_b"}, 32'(hz.fwd_b_o), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic id_nop();
    hz.id_valid_i    = 1'b0;
    hz.id_rs1_i      = '0;
    hz.id_rs2_i      = '0;
    hz.id_use_rs1_i  = 1'b0;
    hz.id_use_rs2_i  = 1'b0;
    hz.id_rd_i       = '0;
    hz.id_regwrite_i = 1'b0;
    hz.id_is_load_i  = 1'b0;
    hz.id_is_mem_i   = 1'b0;
  endtask

  task automatic id_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw,
                       input logic ld, input logic mm);
    hz.id_valid_i    = 1'b1;
    hz.id_rd_i       = rd;
    hz.id_rs1_i      = rs1;
    hz.id_rs2_i      = rs2;
    hz.id_use_rs1_i  = u1;
    hz.id_use_rs2_i  = u2;
    hz.id_regwrite_i = rw;
    hz.id_is_load_i  = ld;
    hz.id_is_mem_i   = mm;
  endtask

  task automatic set_ex(input logic [4:0] a, input logic [4:0] b);
    hz.ex_rs1_i = a;
    hz.ex_rs2_i = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    id_nop();
    set_ex(5'd0, 5'd0);
    hz.brtaken_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hz.dmem_ready_i = 1'b1;
    do_reset();

    // Reset state
    settle();
    check_ctl("rst", 0, 0, 0, 0, 0, 0);
    check_fwd("rst", 2'd0, 2'd0);
    check_eq("rst.err", 32'(hz.err_o), 32'd0);

    // add x5 ; add x6,x5,x1 -> MEM forwarding, no stall
    id_op(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0);
    settle(); check_ctl("alu.c1", 0, 0, 0, 0, 0, 0); tick();
    id_op(5'd6, 5'd5, 5'd1, 1, 1, 1, 0, 0); set_ex(5'd1, 5'd2);
    settle(); check_ctl("alu.c2", 0, 0, 0, 0, 0, 0); check_fwd("alu.c2", 2'd0, 2'd0); tick();
    id_nop(); set_ex(5'd5, 5'd1);
    settle(); check_fwd("alu.c3", 2'd1, 2'd0); check_eq("alu.c3.stall_f", 32'(hz.stall_f_o), 32'd0); tick();
    set_ex(5'd6, 5'd5);
    settle(); check_fwd("alu.c4", 2'd1, 2'd2); tick();

    // Same rd in MEM and WB -> MEM wins, then WB, then register file
    do_reset();
    id_op(5'd3, 5'd1, 5'd2, 1, 1, 1, 0, 0); tick();
    id_op(5'd3, 5'd3, 5'd3, 1, 1, 1, 0, 0); tick();
    id_nop(); tick();
    set_ex(5'd3, 5'd3);
    settle(); check_fwd("prio.mem", 2'd1, 2'd1); tick();
    settle(); check_fwd("prio.wb", 2'd2, 2'd2); tick();
    settle(); check_fwd("prio.rf", 2'd0, 2'd0);

    // lw x5 ; add x6,x1,x5 -> one bubble, then WB forwarding
    do_reset();
    id_op(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 1);
    settle(); check_ctl("ld.c1", 0, 0, 0, 0, 0, 0); tick();
    id_op(5'd6, 5'd1, 5'd5, 1, 1, 1, 0, 0); set_ex(5'd1, 5'd0);
    settle(); check_ctl("ld.c2", 1, 0, 0, 0, 1, 0); tick();
    set_ex(5'd5, 5'd5);
    settle(); check_ctl("ld.c3", 0, 0, 0, 0, 0, 0); check_fwd("ld.c3", 2'd0, 2'd0); tick();
    id_nop(); set_ex(5'd1, 5'd5);
    settle(); check_ctl("ld.c4", 0, 0, 0, 0, 0, 0); check_fwd("ld.c4", 2'd0, 2'd2); tick();

    // Taken branch with a load-use pair behind it -> flush only
    do_reset();
    id_op(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 1); tick();
    id_op(5'd6, 5'd5, 5'd5, 1, 1, 1, 0, 0); hz.brtaken_i = 1'b1;
    settle(); check_ctl("br.c1", 0, 0, 0, 1, 1, 1); tick();
    settle(); check_ctl("br.c2", 0, 0, 0, 0, 0, 0); tick();
    hz.brtaken_i = 1'b0;

    // add x9 ; sw ; beq -- sw waits 3 cycles, beq taken resolves on release
    do_reset();
    id_op(5'd9, 5'd1, 5'd2, 1, 1, 1, 0, 0); tick();
    id_op(5'd0, 5'd1, 5'd2, 1, 1, 0, 0, 1); tick();
    id_op(5'd0, 5'd1, 5'd2, 1, 1, 0, 0, 0); tick();
    id_op(5'd7, 5'd1, 5'd2, 1, 1, 1, 0, 0); set_ex(5'd9, 5'd0);
    hz.dmem_ready_i = 1'b0; hz.brtaken_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_ctl($sformatf("frz.%0d", i), 1, 1, 1, 0, 0, 0);
      check_fwd($sformatf("frz.%0d", i), 2'd2, 2'd0);
      tick();
    end
    hz.dmem_ready_i = 1'b1;
    settle(); check_ctl("frz.rel", 0, 0, 0, 1, 1, 1); check_fwd("frz.rel", 2'd2, 2'd0); tick();
    settle(); check_ctl("frz.after", 0, 0, 0, 0, 0, 0); check_fwd("frz.after", 2'd0, 2'd0); tick();
    hz.brtaken_i = 1'b0;

    // lw stuck in MEM for 64 cycles -> err_o in wait cycle 63, sticky
    do_reset();
    id_op(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 1); tick();
    id_nop(); tick();
    hz.dmem_ready_i = 1'b0;
    for (int k = 0; k < 64; k++) begin
      settle();
      if (k == 0)  check_eq("to.stall_m", 32'(hz.stall_m_o), 32'd1);
      if (k == 62) check_eq("to.err62", 32'(hz.err_o), 32'd0);
      if (k == 63) check_eq("to.err63", 32'(hz.err_o), 32'd1);
      tick();
    end
    hz.dmem_ready_i = 1'b1;
    settle(); check_eq("to.rel.stall_m", 32'(hz.stall_m_o), 32'd0); check_eq("to.rel.err", 32'(hz.err_o), 32'd1); tick();
    settle(); check_eq("to.sticky", 32'(hz.err_o), 32'd1);
    do_reset();
    settle(); check_eq("to.rst.err", 32'(hz.err_o), 32'd0);

    // Reset while frozen -> no outputs held
    id_op(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 1); tick();
    id_nop(); tick();
    hz.dmem_ready_i = 1'b0;
    settle(); check_ctl("rstfrz.pre", 1, 1, 1, 0, 0, 0); tick();
    do_reset();
    settle(); check_ctl("rstfrz.post", 0, 0, 0, 0, 0, 0);
    hz.dmem_ready_i = 1'b1;

    // x0 writes never forwarded; lw x0 never stalls; unused source ignored
    do_reset();
    id_op(5'd0, 5'd1, 5'd2, 1, 1, 1, 0, 0); tick();
    id_op(5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0); tick();
    id_nop(); set_ex(5'd0, 5'd0);
    settle(); check_fwd("x0.mem", 2'd0, 2'd0); tick();
    settle(); check_fwd("x0.wb", 2'd0, 2'd0);
    do_reset();
    id_op(5'd0, 5'd1, 5'd0, 1, 0, 1, 1, 1); tick();
    id_op(5'd6, 5'd0, 5'd0, 1, 1, 1, 0, 0);
    settle(); check_ctl("x0.ld", 0, 0, 0, 0, 0, 0);
    do_reset();
    id_op(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 1); tick();
    id_op(5'd6, 5'd1, 5'd5, 1, 0, 1, 0, 0);
    settle(); check_ctl("nouse.ld", 0, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
